// File: rtl/bel_bfly.sv
// Radix-2 DIT butterfly fed by the twiddle multiplier: aligns A with W*B and emits A+W*B, A-W*B.
// Build option BEL_BFLY_SAT_EN: saturate overflowing unscaled components instead of wrapping.
module bel_bfly #(
    parameter int word_width = 16,
    parameter int CMUL_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pipe_halt,
    input  logic                  valid_i,
    input  logic [word_width-1:0] a_re_i,
    input  logic [word_width-1:0] a_im_i,
    input  logic [word_width-1:0] wb_re_i,
    input  logic [word_width-1:0] wb_im_i,
    input  logic                  scale_i,
    input  logic                  ovf_clr_i,
    output logic [word_width-1:0] x_re_o,
    output logic [word_width-1:0] x_im_o,
    output logic [word_width-1:0] y_re_o,
    output logic [word_width-1:0] y_im_o,
    output logic                  valid_o,
    output logic                  ovf_o
);

    localparam int W = word_width;

    logic signed [W-1:0] a_re_p0 [CMUL_LAT];
    logic signed [W-1:0] a_im_p0 [CMUL_LAT];
    logic                vld_p0  [CMUL_LAT];

    logic signed [W-1:0] x_re_p1, x_im_p1, y_re_p1, y_im_p1;
    logic                vld_p1;
    logic                ovf_q;

    logic signed [W:0]   s_re, s_im, d_re, d_im;
    logic [W-1:0]        x_re_n, x_im_n, y_re_n, y_im_n;
    logic                ovf_hit;

    function automatic logic ovf_of(input logic signed [W:0] v);
        return v[W] ^ v[W-1];
    endfunction

    // (v + 1) >>> 1 kept to W bits: floor(v/2) plus one when v is odd.
    function automatic logic [W-1:0] halve_round(input logic signed [W:0] v);
        return v[W:1] + {{(W-1){1'b0}}, v[0]};
    endfunction

    function automatic logic [W-1:0] fit(input logic signed [W:0] v);
`ifdef BEL_BFLY_SAT_EN
        if (ovf_of(v))
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return v[W-1:0];
`else
        return v[W-1:0];
`endif
    endfunction

    function automatic logic [W-1:0] shape(input logic signed [W:0] v, input logic scale);
        return scale ? halve_round(v) : fit(v);
    endfunction

    // Stage p0: A / valid alignment line matching the multiplier latency
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CMUL_LAT; i++) begin
                a_re_p0[i] <= '0;
                a_im_p0[i] <= '0;
                vld_p0[i]  <= 1'b0;
            end
        end else if (!pipe_halt) begin
            a_re_p0[0] <= a_re_i;
            a_im_p0[0] <= a_im_i;
            vld_p0[0]  <= valid_i;
            for (int i = 1; i < CMUL_LAT; i++) begin
                a_re_p0[i] <= a_re_p0[i-1];
                a_im_p0[i] <= a_im_p0[i-1];
                vld_p0[i]  <= vld_p0[i-1];
            end
        end
    end

    assign s_re = {a_re_p0[CMUL_LAT-1][W-1], a_re_p0[CMUL_LAT-1]} + {wb_re_i[W-1], wb_re_i};
    assign s_im = {a_im_p0[CMUL_LAT-1][W-1], a_im_p0[CMUL_LAT-1]} + {wb_im_i[W-1], wb_im_i};
    assign d_re = {a_re_p0[CMUL_LAT-1][W-1], a_re_p0[CMUL_LAT-1]} - {wb_re_i[W-1], wb_re_i};
    assign d_im = {a_im_p0[CMUL_LAT-1][W-1], a_im_p0[CMUL_LAT-1]} - {wb_im_i[W-1], wb_im_i};

    assign x_re_n = shape(s_re, scale_i);
    assign x_im_n = shape(s_im, scale_i);
    assign y_re_n = shape(d_re, scale_i);
    assign y_im_n = shape(d_im, scale_i);

    // Halving cannot overflow, so only the unscaled path can raise the flag.
    assign ovf_hit = !scale_i && (ovf_of(s_re) || ovf_of(s_im) || ovf_of(d_re) || ovf_of(d_im));

    // Stage p1: butterfly output register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_re_p1 <= '0;
            x_im_p1 <= '0;
            y_re_p1 <= '0;
            y_im_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (!pipe_halt) begin
            x_re_p1 <= x_re_n;
            x_im_p1 <= x_im_n;
            y_re_p1 <= y_re_n;
            y_im_p1 <= y_im_n;
            vld_p1  <= vld_p0[CMUL_LAT-1];
        end
    end

    // Sticky flag: a new overflow beats a simultaneous clear; clear works while halted.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            ovf_q <= 1'b0;
        else if (vld_p0[CMUL_LAT-1] && !pipe_halt && ovf_hit)
            ovf_q <= 1'b1;
        else if (ovf_clr_i)
            ovf_q <= 1'b0;
    end

    assign x_re_o  = x_re_p1;
    assign x_im_o  = x_im_p1;
    assign y_re_o  = y_re_p1;
    assign y_im_o  = y_im_p1;
    assign valid_o = vld_p1;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_bel_bfly.sv
// Scoreboard bench for bel_bfly (word_width=16, CMUL_LAT=2); honours BEL_BFLY_SAT_EN.
module tb_bel_bfly;

    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pipe_halt = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] a_re_i = '0, a_im_i = '0, wb_re_i = '0, wb_im_i = '0;
    logic        scale_i = 1'b0;
    logic        ovf_clr_i = 1'b0;
    logic [15:0] x_re_o, x_im_o, y_re_o, y_im_o;
    logic        valid_o, ovf_o;

    bel_bfly #(.word_width(16), .CMUL_LAT(LAT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pipe_halt(pipe_halt), .valid_i(valid_i),
        .a_re_i(a_re_i), .a_im_i(a_im_i), .wb_re_i(wb_re_i), .wb_im_i(wb_im_i),
        .scale_i(scale_i), .ovf_clr_i(ovf_clr_i),
        .x_re_o(x_re_o), .x_im_o(x_im_o), .y_re_o(y_re_o), .y_im_o(y_im_o),
        .valid_o(valid_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] xr, xi, yr, yi;
        int          iss;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          enc = 0;
    logic [15:0] wq_re[LAT], wq_im[LAT];
    logic        scq[LAT];
    logic        last_v = 1'b0;
    logic [15:0] last_xr = '0, last_xi = '0, last_yr = '0, last_yi = '0;

    // Reference component: rounded halving, else clamp or wrap to 16 bits.
    function automatic logic [15:0] comp(input int s, input logic sc);
        int r;
        if (sc) r = (s + 1) >>> 1;
        else begin
`ifdef BEL_BFLY_SAT_EN
            r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
`else
            r = s;
`endif
        end
        return r[15:0];
    endfunction

    // Output checker: pops the scoreboard on every enabled cycle with valid_o.
    always @(posedge clk_i) begin
        logic en_e, rs_e;
        exp_t e;
        en_e = rst_n_i && !pipe_halt;
        rs_e = !rst_n_i;
        if (en_e) enc++;
        #1;
        if (rs_e) begin
            last_v = 1'b0;
        end else if (en_e) begin
            if (valid_o === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: valid_o=1 with no result pending at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if ({x_re_o, x_im_o, y_re_o, y_im_o} !== {e.xr, e.xi, e.yr, e.yi}) begin
                        n_fail++;
                        $display("FAIL result: got X=(%0d,%0d) Y=(%0d,%0d) want X=(%0d,%0d) Y=(%0d,%0d)",
                                 $signed(x_re_o), $signed(x_im_o), $signed(y_re_o), $signed(y_im_o),
                                 $signed(e.xr), $signed(e.xi), $signed(e.yr), $signed(e.yi));
                    end
                    n_chk++;
                    if (enc - e.iss != LAT + 1) begin
                        n_fail++;
                        $display("FAIL latency: got %0d enabled cycles want %0d", enc - e.iss, LAT + 1);
                    end
                    last_v = 1'b1;
                    {last_xr, last_xi, last_yr, last_yi} = {e.xr, e.xi, e.yr, e.yi};
                end
            end else begin
                last_v = 1'b0;
            end
        end else begin
            n_chk++;
            if (valid_o !== last_v ||
                (last_v && {x_re_o, x_im_o, y_re_o, y_im_o} !== {last_xr, last_xi, last_yr, last_yi})) begin
                n_fail++;
                $display("FAIL halt_hold: got valid=%b X=(%0d,%0d) want valid=%b X=(%0d,%0d)",
                         valid_o, $signed(x_re_o), $signed(x_im_o), last_v, $signed(last_xr), $signed(last_xi));
            end
        end
    end

    // One cycle: A side issued now, multiplier side presents the product issued LAT enabled cycles ago.
    task automatic step(input logic v, input int ar, input int ai, input int br, input int bi,
                        input logic sc, input logic h, input logic clr);
        exp_t e;
        valid_i   = v;
        a_re_i    = ar[15:0];
        a_im_i    = ai[15:0];
        pipe_halt = h;
        ovf_clr_i = clr;
        wb_re_i   = wq_re[LAT-1];
        wb_im_i   = wq_im[LAT-1];
        scale_i   = scq[LAT-1];
        if (v && !h) begin
            e.xr  = comp(ar + br, sc);
            e.xi  = comp(ai + bi, sc);
            e.yr  = comp(ar - br, sc);
            e.yi  = comp(ai - bi, sc);
            e.iss = enc;
            sb.push_back(e);
        end
        @(posedge clk_i);
        if (!h) begin
            for (int i = LAT - 1; i > 0; i--) begin
                wq_re[i] = wq_re[i-1];
                wq_im[i] = wq_im[i-1];
                scq[i]   = scq[i-1];
            end
            wq_re[0] = br[15:0];
            wq_im[0] = bi[15:0];
            scq[0]   = sc;
        end
        @(negedge clk_i);
        ovf_clr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic h);
        rst_n_i   = 1'b0;
        valid_i   = 1'b0;
        pipe_halt = h;
        ovf_clr_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i   = 1'b1;
        pipe_halt = 1'b0;
        sb.delete();
        for (int i = 0; i < LAT; i++) begin
            wq_re[i] = '0;
            wq_im[i] = '0;
            scq[i]   = 1'b0;
        end
    endtask

    task automatic check_cleared(input string tag);
        n_chk++;
        if ({x_re_o, x_im_o, y_re_o, y_im_o, valid_o, ovf_o} !== 66'd0) begin
            n_fail++;
            $display("FAIL %s: got X=(%0d,%0d) Y=(%0d,%0d) valid=%b ovf=%b want all 0", tag,
                     $signed(x_re_o), $signed(x_im_o), $signed(y_re_o), $signed(y_im_o), valid_o, ovf_o);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        check_cleared("reset_state");
    endtask

    task automatic test_basic();
        step(1'b1, 1000, -2000, 300, 400, 1'b0, 1'b0, 1'b0);
        idle(2);
        n_chk++;
        if ({x_re_o, x_im_o, y_re_o, y_im_o, valid_o, ovf_o} !==
            {16'd1300, -16'sd1600, 16'd700, -16'sd2400, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic: got X=(%0d,%0d) Y=(%0d,%0d) v=%b ovf=%b want X=(1300,-1600) Y=(700,-2400) v=1 ovf=0",
                     $signed(x_re_o), $signed(x_im_o), $signed(y_re_o), $signed(y_im_o), valid_o, ovf_o);
        end
    endtask

    task automatic test_rounding();
        step(1'b1, 3, -3, 2, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_chk++;
        if ({x_re_o, x_im_o, y_re_o, y_im_o} !== {16'd3, -16'sd1, 16'd1, -16'sd1}) begin
            n_fail++;
            $display("FAIL rounding: got X=(%0d,%0d) Y=(%0d,%0d) want X=(3,-1) Y=(1,-1)",
                     $signed(x_re_o), $signed(x_im_o), $signed(y_re_o), $signed(y_im_o));
        end
        // Large-magnitude halving must not flag overflow.
        step(1'b1, 32767, -32768, 32767, -32768, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_chk++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL scaled_no_ovf: got ovf=%b want 0", ovf_o);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want_xr, want_yi;
`ifdef BEL_BFLY_SAT_EN
        want_xr = 16'sd32767;
        want_yi = -16'sd32768;
`else
        want_xr = -16'sd25536;
        want_yi = 16'sd25536;
`endif
        step(1'b1, 30000, -30000, 10000, 10000, 1'b0, 1'b0, 1'b0);
        idle(2);
        n_chk++;
        if ({x_re_o, y_im_o, ovf_o} !== {want_xr, want_yi, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow: got X_re=%0d Y_im=%0d ovf=%b want X_re=%0d Y_im=%0d ovf=1",
                     $signed(x_re_o), $signed(y_im_o), ovf_o, $signed(want_xr), $signed(want_yi));
        end
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b want 0", ovf_o);
        end
        step(1'b1, 30000, -30000, 10000, 10000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%b want 1", ovf_o);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 111, 222, 333, 444, 1'b0, 1'b0, 1'b0);
        step(1'b1, -555, 666, 77, -88, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        check_cleared("reset_mid");
        idle(5);
    endtask

    task automatic test_halt();
        step(1'b1, 10, 20, 1, 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, -30, 40, 3, -4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 500, -600, -50, 60, 1'b0, 1'b0, 1'b0);
        step(1'b1, -7000, 8000, 700, 800, 1'b1, 1'b0, 1'b0);
        idle(4);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL halt_lost: got %0d results pending want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic pat[7];
        logic want[7];
        want = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        step(1'b1, 1, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        pat[0] = valid_o;
        step(1'b0, 9, 9, 9, 9, 1'b0, 1'b0, 1'b0);
        pat[1] = valid_o;
        step(1'b1, -5, 6, 7, -8, 1'b0, 1'b0, 1'b0);
        pat[2] = valid_o;
        step(1'b1, 1234, -4321, -99, 99, 1'b0, 1'b0, 1'b0);
        pat[3] = valid_o;
        for (int i = 4; i < 7; i++) begin
            step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            pat[i] = valid_o;
        end
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (pat[i] !== want[i]) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", i, pat[i], want[i]);
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_lost: got %0d results pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_reset_mid();
        test_halt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
